// File: rtl/sm_clk_sequencer_pkg.sv
// Shared definitions for the CPU run-control sequencer.
package sm_clk_sequencer_pkg;

  // Extra prescaler bits beyond SHIFT so the largest divide offset still fits.
  localparam int unsigned PRE_EXTRA_W = 16;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } sm_state_e;

endpackage

// File: rtl/sm_tick_prescaler.sv
// Free-running prescaler: counts while enabled and flags "due" at the terminal value.
module sm_tick_prescaler
  import sm_clk_sequencer_pkg::*;
#(
  parameter int unsigned SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] divide,
  output logic       due
);

  localparam int unsigned PW = SHIFT + PRE_EXTRA_W;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic [PW-1:0] term;

  // >= rather than == so a divide reduced below the current count fires at once.
  always_comb begin
    term  = (PW'(1) << (SHIFT + int'(divide))) - PW'(1);
    due   = enable && (cnt_q >= term);
    cnt_d = cnt_q + PW'(1);
    if (!enable || clear || due) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_clk_sequencer.sv
// Run-control sequencer: free run / stop / step / burst / PC breakpoint,
// producing single-cycle CPU advance strobes from a prescaled main clock.
module sm_clk_sequencer
  import sm_clk_sequencer_pkg::*;
#(
  parameter int unsigned SHIFT   = 16,
  parameter int unsigned BURST_W = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         divide,
  input  logic               run_req,
  input  logic               stop_req,
  input  logic               step_req,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_enable,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               tick,
  output logic [1:0]         state,
  output logic               busy,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   cycle_count
);

  sm_state_e          state_q, state_d;
  logic               tick_q, tick_d;
  logic               bp_hit_q, bp_hit_d;
  logic               first_q, first_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic due;
  logic start;
  logic pre_clear;
  logic bp_match;

  sm_tick_prescaler #(
    .SHIFT (SHIFT)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q != ST_HALT),
    .clear  (pre_clear),
    .divide (divide),
    .due    (due)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = 1'b0;
    bp_hit_d  = bp_hit_q;
    first_d   = first_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    // The first tick after a start bypasses the breakpoint so execution can leave it.
    bp_match  = bp_enable && (pc == bp_addr) && !first_q;

    if (stop_req) begin
      state_d = ST_HALT;
      rem_d   = '0;
    end else if (state_q == ST_HALT) begin
      if (step_req) begin
        state_d = ST_STEP;
        start   = 1'b1;
      end else if (burst_req && (burst_len != '0)) begin
        state_d = ST_BURST;
        rem_d   = burst_len;
        start   = 1'b1;
      end else if (run_req) begin
        state_d = ST_RUN;
        start   = 1'b1;
      end
      if (start) begin
        bp_hit_d = 1'b0;
        first_d  = 1'b1;
      end
    end else if (due) begin
      if (bp_match) begin
        state_d  = ST_HALT;
        bp_hit_d = 1'b1;
        rem_d    = '0;
      end else begin
        tick_d  = 1'b1;
        first_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
          ST_STEP:  state_d = ST_HALT;
          ST_BURST: begin
            rem_d = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) begin
              state_d = ST_HALT;
            end
          end
          default:  state_d = state_q;
        endcase
      end
    end

    pre_clear = stop_req || start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HALT;
      tick_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      first_q  <= 1'b0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bp_hit_q <= bp_hit_d;
      first_q  <= first_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick        = tick_q;
  assign state       = state_q;
  assign busy        = (state_q != ST_HALT);
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_sm_clk_sequencer.sv
// Scoreboard bench for sm_clk_sequencer (SHIFT=2 so the base tick period is 4 clks).
module tb_sm_clk_sequencer;

  localparam int unsigned SHIFT   = 2;
  localparam int unsigned BURST_W = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MOD = 1 << CNT_W;
  localparam int unsigned PERIOD  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         divide;
  logic               run_req, stop_req, step_req, burst_req;
  logic [BURST_W-1:0] burst_len;
  logic               bp_enable;
  logic [31:0]        bp_addr, pc;
  logic               tick;
  logic [1:0]         state;
  logic               busy;
  logic               bp_hit;
  logic [CNT_W-1:0]   cycle_count;

  sm_clk_sequencer #(
    .SHIFT   (SHIFT),
    .BURST_W (BURST_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .divide      (divide),
    .run_req     (run_req),
    .stop_req    (stop_req),
    .step_req    (step_req),
    .burst_req   (burst_req),
    .burst_len   (burst_len),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .tick        (tick),
    .state       (state),
    .busy        (busy),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int unsigned at;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int unsigned n_vec     = 0;
  int unsigned n_err     = 0;
  int unsigned model_cnt = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edges);
    end
  endtask

  // Reference: a tick is expected on a given clock edge, with the counter one higher.
  task automatic expect_tick(input int unsigned at);
    model_cnt = (model_cnt + 1) % CNT_MOD;
    sb.push_back('{at: at, cnt: model_cnt});
  endtask

  // Called on a negedge: request is sampled on the next posedge (returned as acc).
  task automatic pulse(input logic s, input logic st, input logic b, input logic r,
                       output int unsigned acc);
    stop_req  = s;
    step_req  = st;
    burst_req = b;
    run_req   = r;
    acc       = edges + 1;
    @(negedge clk);
    stop_req  = 1'b0;
    step_req  = 1'b0;
    burst_req = 1'b0;
    run_req   = 1'b0;
  endtask

  task automatic wait_edge(input int unsigned n);
    while (edges < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && tick) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: tick seen at edge %0d, none expected", edges);
      end else begin
        e_mon = sb.pop_front();
        check("tick_edge", edges, e_mon.at);
        check("tick_count", cycle_count, e_mon.cnt);
      end
    end
  end

  initial begin
    int unsigned a, a2, s, d, len, n;
    rst       = 1'b1;
    divide    = 4'd0;
    run_req   = 1'b0;
    stop_req  = 1'b0;
    step_req  = 1'b0;
    burst_req = 1'b0;
    burst_len = '0;
    bp_enable = 1'b0;
    bp_addr   = 32'h0;
    pc        = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_count", cycle_count, 0);
    repeat (20) @(negedge clk);
    check("idle_state", state, 0);
    check("idle_count", cycle_count, 0);

    // Single step; second request while stepping must be ignored
    pulse(0, 1, 0, 0, a);
    check("step_state", state, 2);
    expect_tick(a + PERIOD);
    wait_edge(a + 2);
    pulse(0, 1, 0, 0, d);
    wait_edge(a + PERIOD + 3);
    check("step_done_state", state, 0);
    check("step_done_busy", busy, 0);
    check("step_done_count", cycle_count, model_cnt);

    // Burst of 5, then zero-length burst
    burst_len = 16'd5;
    pulse(0, 0, 1, 0, a);
    check("burst_state", state, 3);
    for (int unsigned k = 1; k <= 5; k++) expect_tick(a + k * PERIOD);
    wait_edge(a + 5 * PERIOD + 1);
    check("burst_done_state", state, 0);
    check("burst_done_count", cycle_count, model_cnt);
    burst_len = '0;
    pulse(0, 0, 1, 0, a);
    check("burst0_state", state, 0);
    check("burst0_busy", busy, 0);

    // Random burst lengths; still bursting just before the last tick
    repeat (4) begin
      len = $urandom_range(1, 6);
      burst_len = BURST_W'(len);
      pulse(0, 0, 1, 0, a);
      for (int unsigned k = 1; k <= len; k++) expect_tick(a + k * PERIOD);
      wait_edge(a + len * PERIOD - 1);
      check("rburst_busy_state", state, 3);
      wait_edge(a + len * PERIOD + 1);
      check("rburst_done_state", state, 0);
    end

    // Run, then stop+step together at a random point after the 3rd tick
    pulse(0, 0, 0, 1, a);
    check("run_state", state, 1);
    s = a + 13 + $urandom_range(0, 3);
    for (int unsigned k = 1; a + k * PERIOD < s; k++) expect_tick(a + k * PERIOD);
    wait_edge(s - 1);
    pulse(1, 1, 0, 0, d);
    check("stop_state", state, 0);
    repeat (10) @(negedge clk);
    check("stop_state_later", state, 0);
    check("stop_count", cycle_count, model_cnt);

    // Breakpoint on the 3rd tick, step off it, resume and hit again
    bp_enable = 1'b1;
    bp_addr   = 32'h10;
    pc        = 32'h0;
    pulse(0, 0, 0, 1, a);
    expect_tick(a + PERIOD);
    expect_tick(a + 2 * PERIOD);
    wait_edge(a + 2 * PERIOD);
    pc = 32'h10;
    wait_edge(a + 3 * PERIOD);
    check("bp_state", state, 0);
    check("bp_hit_set", bp_hit, 1);
    check("bp_count", cycle_count, model_cnt);
    repeat (5) @(negedge clk);
    check("bp_hit_held", bp_hit, 1);
    pulse(0, 1, 0, 0, a2);
    check("bp_hit_clear", bp_hit, 0);
    expect_tick(a2 + PERIOD);
    wait_edge(a2 + PERIOD + 2);
    check("bp_step_state", state, 0);
    check("bp_step_hit", bp_hit, 0);
    pulse(0, 0, 0, 1, a);
    expect_tick(a + PERIOD);
    wait_edge(a + 2 * PERIOD + 1);
    check("bp_resume_state", state, 0);
    check("bp_resume_hit", bp_hit, 1);
    bp_enable = 1'b0;
    pc        = 32'h0;

    // divide 2 -> 0 while the prescaler sits at 9
    divide = 4'd2;
    pulse(0, 0, 0, 1, a);
    wait_edge(a + 9);
    divide = 4'd0;
    expect_tick(a + 10);
    expect_tick(a + 14);
    expect_tick(a + 18);
    wait_edge(a + 18);
    pulse(1, 0, 0, 0, d);
    check("div_stop_state", state, 0);

    // Run long enough for the tick counter to wrap
    n = CNT_MOD - model_cnt + 2;
    pulse(0, 0, 0, 1, a);
    for (int unsigned k = 1; k <= n; k++) expect_tick(a + k * PERIOD);
    wait_edge(a + n * PERIOD);
    pulse(1, 0, 0, 0, d);
    check("wrap_count", cycle_count, model_cnt);

    // Asynchronous reset in the middle of a run
    pulse(0, 0, 0, 1, a);
    expect_tick(a + PERIOD);
    wait_edge(a + PERIOD + 2);
    #1 rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_busy", busy, 0);
    check("arst_tick", tick, 0);
    check("arst_count", cycle_count, 0);
    check("arst_bp_hit", bp_hit, 0);
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_idle_state", state, 0);
    pulse(0, 1, 0, 0, a);
    expect_tick(a + PERIOD);
    wait_edge(a + PERIOD + 2);
    check("arst_step_count", cycle_count, 1);

    for (int unsigned i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      e_mon = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_tick: no tick seen, expected at edge %0d", e_mon.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
